// File: rtl/md5_compress_engine_if.sv
// Block-level bus for the MD5 compression engine: start/abort handshake,
// message block and chaining value in, status and digest out.
interface md5_compress_engine_if;
  logic         start_i;
  logic         abort_i;
  logic [511:0] M_i;
  logic [127:0] H_i;
  logic         ready_o;
  logic         busy_o;
  logic         done_o;
  logic [127:0] H_o;

  // Requester side drives the block and observes status
  modport master (
    output start_i, abort_i, M_i, H_i,
    input  ready_o, busy_o, done_o, H_o
  );

  // Engine side
  modport slave (
    input  start_i, abort_i, M_i, H_i,
    output ready_o, busy_o, done_o, H_o
  );
endinterface

// File: rtl/md5_compress_engine.sv
// MD5 single-block compression engine. Runs the 64 RFC 1321 steps,
// STEPS_PER_CYC at a time, and optionally adds the chaining input back in.
module md5_compress_engine #(
  parameter int unsigned STEPS_PER_CYC = 1,
  parameter bit          FEED_FWD      = 1'b1
) (
  input logic                  clk_i,
  input logic                  rst_i,
  md5_compress_engine_if.slave bus
);

  if (!(STEPS_PER_CYC == 1 || STEPS_PER_CYC == 2 || STEPS_PER_CYC == 4)) begin : g_bad_steps
    $error("md5_compress_engine: STEPS_PER_CYC must be 1, 2 or 4");
  end

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  // Counter value at the start of the final RUN cycle
  localparam logic [5:0] LastStep = 6'(64 - STEPS_PER_CYC);
  localparam logic [5:0] StepInc  = 6'(STEPS_PER_CYC);

  localparam logic [31:0] KTable [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  // Rotate amounts indexed by {round, t mod 4}
  localparam logic [4:0] RotTable [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  // One MD5 step on packed {D,C,B,A}; returns the new {D,C,B,A}
  function automatic logic [127:0] md5_step(input logic [127:0] st, input logic [5:0] t,
                                            input logic [511:0] m);
    logic [31:0] a, b, c, d, f, sum, rot;
    logic [3:0]  t4, g;
    logic [4:0]  s;
    a  = st[31:0];
    b  = st[63:32];
    c  = st[95:64];
    d  = st[127:96];
    t4 = t[3:0];
    // Message indices are mod 16, so 4-bit wraparound does the reduction
    case (t[5:4])
      2'd0:    begin f = (b & c) | (~b & d); g = t4;                       end
      2'd1:    begin f = (b & d) | (c & ~d); g = t4 + (t4 << 2) + 4'd1;    end
      2'd2:    begin f = b ^ c ^ d;          g = t4 + (t4 << 1) + 4'd5;    end
      default: begin f = c ^ (b | ~d);       g = (t4 << 3) - t4;           end
    endcase
    s   = RotTable[{t[5:4], t[1:0]}];
    sum = a + f + KTable[t] + m[32*g +: 32];
    rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
    return {c, b, b + rot, d};
  endfunction

  logic [1:0]   r_state;
  logic [5:0]   r_step;
  logic [511:0] r_m;
  logic [127:0] r_h_in;
  logic [127:0] r_st;
  logic [127:0] r_h_o;

  logic [1:0]   w_state_nxt;
  logic [127:0] w_next;
  logic [127:0] w_res;
  logic         w_ready;
  logic         w_done;
  logic         w_accept;
  logic         w_last;

  assign w_ready  = (r_state != StRun);
  assign w_done   = (r_state == StDone) && !bus.abort_i;
  assign w_last   = (r_step == LastStep);
  // Abort in DONE outranks a start; in IDLE abort is ignored
  assign w_accept = bus.start_i && w_ready && !(bus.abort_i && r_state == StDone);

  assign bus.ready_o = w_ready;
  assign bus.busy_o  = (r_state == StRun);
  assign bus.done_o  = w_done;
  // Digest is visible combinationally in the DONE cycle, then held in r_h_o
  assign bus.H_o     = w_done ? w_res : r_h_o;

  // Chain STEPS_PER_CYC consecutive steps starting at the current counter
  always_comb begin
    w_next = r_st;
    for (int k = 0; k < STEPS_PER_CYC; k++) begin
      w_next = md5_step(w_next, r_step + 6'(k), r_m);
    end
  end

  // Final result, with or without the chaining feed-forward
  always_comb begin
    w_res = '0;
    for (int j = 0; j < 4; j++) begin
      w_res[32*j +: 32] = FEED_FWD ? r_h_in[32*j +: 32] + r_st[32*j +: 32] : r_st[32*j +: 32];
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle: if (w_accept) w_state_nxt = StRun;
      StRun: begin
        if (bus.abort_i)  w_state_nxt = StIdle;
        else if (w_last)  w_state_nxt = StDone;
      end
      StDone: w_state_nxt = w_accept ? StRun : StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // Block latch on acceptance, step datapath while running
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_step <= '0;
      r_m    <= '0;
      r_h_in <= '0;
      r_st   <= '0;
    end else if (w_accept) begin
      r_step <= '0;
      r_m    <= bus.M_i;
      r_h_in <= bus.H_i;
      r_st   <= bus.H_i;
    end else if (r_state == StRun) begin
      r_st <= w_next;
      if (!w_last) r_step <= r_step + StepInc;
    end
  end

  // Hold the last delivered digest
  always_ff @(posedge clk_i) begin
    if (rst_i)       r_h_o <= '0;
    else if (w_done) r_h_o <= w_res;
  end

endmodule

// File: tb/tb_md5_compress_engine.sv
// Self-checking bench for md5_compress_engine: known vectors, timing,
// back-to-back, abort, reset and randomized blocks against a reference model.
module tb_md5_compress_engine;

  localparam int I1 = 0;
  localparam int I2 = 1;
  localparam int I4 = 2;
  localparam int IR = 3;

  localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] EMPTY_DIG = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] ABC_DIG   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   start_v;
  logic         tb_abort;
  logic [511:0] tb_m;
  logic [127:0] tb_h;
  logic [511:0] m_empty;
  logic [511:0] m_abc;

  logic [3:0]   done_v, busy_v, ready_v;
  logic [127:0] hout [4];

  int           pass_cnt = 0;
  int           chk_cnt  = 0;
  int           first_done [4];
  logic [127:0] hcap [4];

  always #5 clk = ~clk;

  md5_compress_engine_if if_s1 ();
  md5_compress_engine_if if_s2 ();
  md5_compress_engine_if if_s4 ();
  md5_compress_engine_if if_raw ();

  assign if_s1.start_i  = start_v[I1];
  assign if_s2.start_i  = start_v[I2];
  assign if_s4.start_i  = start_v[I4];
  assign if_raw.start_i = start_v[IR];
  assign if_s1.abort_i  = tb_abort;
  assign if_s2.abort_i  = tb_abort;
  assign if_s4.abort_i  = tb_abort;
  assign if_raw.abort_i = tb_abort;
  assign if_s1.M_i  = tb_m;
  assign if_s2.M_i  = tb_m;
  assign if_s4.M_i  = tb_m;
  assign if_raw.M_i = tb_m;
  assign if_s1.H_i  = tb_h;
  assign if_s2.H_i  = tb_h;
  assign if_s4.H_i  = tb_h;
  assign if_raw.H_i = tb_h;

  assign done_v  = {if_raw.done_o, if_s4.done_o, if_s2.done_o, if_s1.done_o};
  assign busy_v  = {if_raw.busy_o, if_s4.busy_o, if_s2.busy_o, if_s1.busy_o};
  assign ready_v = {if_raw.ready_o, if_s4.ready_o, if_s2.ready_o, if_s1.ready_o};
  assign hout[I1] = if_s1.H_o;
  assign hout[I2] = if_s2.H_o;
  assign hout[I4] = if_s4.H_o;
  assign hout[IR] = if_raw.H_o;

  md5_compress_engine #(.STEPS_PER_CYC(1), .FEED_FWD(1'b1)) u_dut_s1 (
    .clk_i(clk), .rst_i(rst), .bus(if_s1));
  md5_compress_engine #(.STEPS_PER_CYC(2), .FEED_FWD(1'b1)) u_dut_s2 (
    .clk_i(clk), .rst_i(rst), .bus(if_s2));
  md5_compress_engine #(.STEPS_PER_CYC(4), .FEED_FWD(1'b1)) u_dut_s4 (
    .clk_i(clk), .rst_i(rst), .bus(if_s4));
  md5_compress_engine #(.STEPS_PER_CYC(1), .FEED_FWD(1'b0)) u_dut_raw (
    .clk_i(clk), .rst_i(rst), .bus(if_raw));

  // Straight RFC 1321 compression; K derived from sin() rather than a table
  function automatic logic [127:0] md5_ref(input logic [511:0] m, input logic [127:0] h,
                                           input bit ff);
    int          sh [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    logic [31:0] w [16];
    logic [31:0] a, b, c, d, f, x, kk, tmp;
    int          g, s;
    real         r;
    for (int j = 0; j < 16; j++) w[j] = m[32*j +: 32];
    a = h[31:0];
    b = h[63:32];
    c = h[95:64];
    d = h[127:96];
    for (int i = 0; i < 64; i++) begin
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kk = 32'(longint'($floor(r * 4294967296.0)));
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;                end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
      s   = sh[(i / 16) * 4 + (i % 4)];
      x   = a + f + kk + w[g];
      x   = (x << s) | (x >> (32 - s));
      tmp = d;
      d   = c;
      c   = b;
      b   = b + x;
      a   = tmp;
    end
    if (ff) return {h[127:96] + d, h[95:64] + c, h[63:32] + b, h[31:0] + a};
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] add_words(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    for (int j = 0; j < 4; j++) z[32*j +: 32] = x[32*j +: 32] + y[32*j +: 32];
    return z;
  endfunction

  // Called at a negedge; presents a block for one cycle, returns at the next negedge
  task automatic launch(input logic [3:0] mask, input logic [511:0] m, input logic [127:0] h);
    tb_m    = m;
    tb_h    = h;
    start_v = mask;
    @(negedge clk);
    start_v = '0;
  endtask

  // Counts cycles from 1 at the current negedge until done_o of one engine
  task automatic wait_done(input int idx, input int budget, output int lat);
    int cyc = 1;
    while (done_v[idx] !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    lat = (done_v[idx] === 1'b1) ? cyc : -1;
  endtask

  task automatic watch_all(input int window);
    for (int i = 0; i < 4; i++) begin
      first_done[i] = -1;
      hcap[i]       = '0;
    end
    for (int cyc = 1; cyc <= window; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (done_v[i] === 1'b1 && first_done[i] < 0) begin
          first_done[i] = cyc;
          hcap[i]       = hout[i];
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    start_v  = '0;
    tb_abort = 1'b0;
    tb_m     = '0;
    tb_h     = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (ready_v[i] !== 1'b1) $display("FAIL reset_ready[%0d]: got %b want 1", i, ready_v[i]);
      else pass_cnt++;
      chk_cnt++;
      if (busy_v[i] !== 1'b0) $display("FAIL reset_busy[%0d]: got %b want 0", i, busy_v[i]);
      else pass_cnt++;
      chk_cnt++;
      if (done_v[i] !== 1'b0) $display("FAIL reset_done[%0d]: got %b want 0", i, done_v[i]);
      else pass_cnt++;
      chk_cnt++;
      if (hout[i] !== '0) $display("FAIL reset_hout[%0d]: got %h want 0", i, hout[i]);
      else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_empty;
    int lat;
    launch(4'b0001, m_empty, IV);
    chk_cnt++;
    if (busy_v[I1] !== 1'b1 || ready_v[I1] !== 1'b0)
      $display("FAIL empty_run_status: busy %b ready %b want 1 0", busy_v[I1], ready_v[I1]);
    else pass_cnt++;
    wait_done(I1, 200, lat);
    chk_cnt++;
    if (lat !== 65) $display("FAIL empty_latency: got %0d want 65", lat);
    else pass_cnt++;
    chk_cnt++;
    if (hout[I1] !== EMPTY_DIG) $display("FAIL empty_digest: got %h want %h", hout[I1], EMPTY_DIG);
    else pass_cnt++;
    chk_cnt++;
    if (busy_v[I1] !== 1'b0 || ready_v[I1] !== 1'b1)
      $display("FAIL empty_done_status: busy %b ready %b want 0 1", busy_v[I1], ready_v[I1]);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done_v[I1] !== 1'b0 || hout[I1] !== EMPTY_DIG)
      $display("FAIL empty_hold: done %b hout %h want 0 %h", done_v[I1], hout[I1], EMPTY_DIG);
    else pass_cnt++;
  endtask

  task automatic test_abc_all;
    int want_lat [4] = '{65, 33, 17, 65};
    launch(4'b1111, m_abc, IV);
    watch_all(80);
    for (int i = 0; i < 4; i++) begin
      chk_cnt++;
      if (first_done[i] !== want_lat[i])
        $display("FAIL abc_latency[%0d]: got %0d want %0d", i, first_done[i], want_lat[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (hcap[i] !== ABC_DIG) $display("FAIL abc_digest[%0d]: got %h want %h", i, hcap[i], ABC_DIG);
      else pass_cnt++;
    end
    chk_cnt++;
    if (add_words(hcap[IR], IV) !== ABC_DIG)
      $display("FAIL abc_raw_plus_iv: got %h want %h", add_words(hcap[IR], IV), ABC_DIG);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(4'b0001, m_empty, IV);
    wait_done(I1, 200, lat);
    chk_cnt++;
    if (lat !== 65 || hout[I1] !== EMPTY_DIG)
      $display("FAIL b2b_first: lat %0d hout %h want 65 %h", lat, hout[I1], EMPTY_DIG);
    else pass_cnt++;
    chk_cnt++;
    if (ready_v[I1] !== 1'b1) $display("FAIL b2b_ready_in_done: got %b want 1", ready_v[I1]);
    else pass_cnt++;
    launch(4'b0001, m_abc, IV);
    chk_cnt++;
    if (busy_v[I1] !== 1'b1) $display("FAIL b2b_no_gap: busy %b want 1", busy_v[I1]);
    else pass_cnt++;
    wait_done(I1, 200, lat);
    chk_cnt++;
    if (lat !== 65) $display("FAIL b2b_latency: got %0d want 65", lat);
    else pass_cnt++;
    chk_cnt++;
    if (hout[I1] !== ABC_DIG) $display("FAIL b2b_digest: got %h want %h", hout[I1], ABC_DIG);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int lat;
    int ndone;
    // Abort with a concurrent start, mid-run
    launch(4'b0001, m_empty, IV);
    repeat (19) @(negedge clk);
    tb_abort = 1'b1;
    start_v  = 4'b0001;
    tb_m     = m_abc;
    #1;
    chk_cnt++;
    if (done_v[I1] !== 1'b0) $display("FAIL abort_run_done: got %b want 0", done_v[I1]);
    else pass_cnt++;
    @(negedge clk);
    tb_abort = 1'b0;
    start_v  = '0;
    chk_cnt++;
    if (busy_v[I1] !== 1'b0 || ready_v[I1] !== 1'b1)
      $display("FAIL abort_run_idle: busy %b ready %b want 0 1", busy_v[I1], ready_v[I1]);
    else pass_cnt++;
    chk_cnt++;
    if (hout[I1] !== ABC_DIG) $display("FAIL abort_run_hold: got %h want %h", hout[I1], ABC_DIG);
    else pass_cnt++;
    ndone = 0;
    repeat (80) begin
      if (done_v[I1] === 1'b1) ndone++;
      @(negedge clk);
    end
    chk_cnt++;
    if (ndone !== 0) $display("FAIL abort_no_done: got %0d pulses want 0", ndone);
    else pass_cnt++;
    launch(4'b0001, m_abc, IV);
    wait_done(I1, 200, lat);
    chk_cnt++;
    if (lat !== 65 || hout[I1] !== ABC_DIG)
      $display("FAIL abort_recover: lat %0d hout %h want 65 %h", lat, hout[I1], ABC_DIG);
    else pass_cnt++;
    @(negedge clk);
    // Abort landing in the DONE cycle, with a concurrent start
    launch(4'b0001, m_empty, IV);
    wait_done(I1, 200, lat);
    tb_abort = 1'b1;
    start_v  = 4'b0001;
    #1;
    chk_cnt++;
    if (done_v[I1] !== 1'b0 || hout[I1] !== ABC_DIG)
      $display("FAIL abort_done_suppress: done %b hout %h want 0 %h", done_v[I1], hout[I1], ABC_DIG);
    else pass_cnt++;
    @(negedge clk);
    tb_abort = 1'b0;
    start_v  = '0;
    chk_cnt++;
    if (busy_v[I1] !== 1'b0 || ready_v[I1] !== 1'b1 || hout[I1] !== ABC_DIG)
      $display("FAIL abort_done_idle: busy %b ready %b hout %h want 0 1 %h",
               busy_v[I1], ready_v[I1], hout[I1], ABC_DIG);
    else pass_cnt++;
  endtask

  task automatic test_reset_midrun;
    logic [511:0] m;
    int ndone;
    for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom();
    launch(4'b0001, m, IV);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    start_v  = 4'b0001;
    tb_abort = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    start_v  = '0;
    tb_abort = 1'b0;
    chk_cnt++;
    if (ready_v[I1] !== 1'b1 || busy_v[I1] !== 1'b0 || hout[I1] !== '0)
      $display("FAIL midrun_reset: ready %b busy %b hout %h want 1 0 0",
               ready_v[I1], busy_v[I1], hout[I1]);
    else pass_cnt++;
    ndone = 0;
    repeat (100) begin
      if (done_v[I1] === 1'b1) ndone++;
      @(negedge clk);
    end
    chk_cnt++;
    if (ndone !== 0) $display("FAIL midrun_no_done: got %0d pulses want 0", ndone);
    else pass_cnt++;
  endtask

  task automatic test_raw_start_ignored;
    int lat;
    launch(4'b1000, m_abc, IV);
    repeat (9) @(negedge clk);
    start_v = 4'b1000;
    for (int j = 0; j < 16; j++) tb_m[32*j +: 32] = $urandom();
    for (int j = 0; j < 4; j++) tb_h[32*j +: 32] = $urandom();
    @(negedge clk);
    start_v = '0;
    wait_done(IR, 200, lat);
    chk_cnt++;
    if (lat !== 55) $display("FAIL raw_ignore_latency: got %0d want 55", lat);
    else pass_cnt++;
    chk_cnt++;
    if (add_words(hout[IR], IV) !== ABC_DIG)
      $display("FAIL raw_ignore_digest: got %h want %h", add_words(hout[IR], IV), ABC_DIG);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [511:0] m;
    logic [127:0] h;
    logic [127:0] want_ff, want_raw;
    int want_lat [4] = '{65, 33, 17, 65};
    for (int n = 0; n < 5; n++) begin
      for (int j = 0; j < 16; j++) m[32*j +: 32] = $urandom();
      for (int j = 0; j < 4; j++) h[32*j +: 32] = $urandom();
      want_ff  = md5_ref(m, h, 1'b1);
      want_raw = md5_ref(m, h, 1'b0);
      launch(4'b1111, m, h);
      watch_all(80);
      for (int i = 0; i < 4; i++) begin
        chk_cnt++;
        if (first_done[i] !== want_lat[i])
          $display("FAIL rand%0d_latency[%0d]: got %0d want %0d", n, i, first_done[i], want_lat[i]);
        else pass_cnt++;
        chk_cnt++;
        if (hcap[i] !== ((i == IR) ? want_raw : want_ff))
          $display("FAIL rand%0d_digest[%0d]: got %h want %h", n, i, hcap[i],
                   (i == IR) ? want_raw : want_ff);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    m_empty      = '0;
    m_empty[31:0] = 32'h00000080;
    m_abc        = '0;
    m_abc[31:0]  = 32'h80636261;
    m_abc[479:448] = 32'h00000018;
    test_reset();
    test_empty();
    test_abc_all();
    test_back_to_back();
    test_abort();
    test_reset_midrun();
    test_raw_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
